motoro3_gate_deadtime: RTL and testbench
========================================

// Module: motoro3_gate_deadtime
// PURPOSE
//  Downstream stage of the 3-phase commutation state machine. Converts per-phase enable/high-low
//  commands plus the chopping pwm into six registered half-bridge gate drives (aHG/aLG..cHG/cLG).
//  Inserts dead-time on every change of conducting switch; guarantees no shoot-through.
//  Latches a fault (external or m3step==7); all gates stay off until cleared.
// PARAMETERS
//  DEAD_CYC  20  clk cycles both gates of a phase are held off before either turns on (2us @10MHz)
//  DW        8   width of per-phase dead-time counter; DEAD_CYC must be in 1..2**DW-1
// PORTS
//  clk         in   1  system clock, 10MHz; all logic on its rising edge
//  rst         in   1  synchronous reset, active-high
//  pwm         in   1  chopping pwm from the pwm generator
//  aE,bE,cE    in   1  phase enable (0: phase floating)
//  aH1_L0..cH1_L0 in 1 per phase: 1 high-side conducts, 0 low-side conducts (valid when xE=1)
//  m3step      in   4  commutation step; 4'd7 = force stop
//  fault       in   1  external over-current/driver fault, level sensitive
//  flt_clr     in   1  single-cycle pulse, clears latched fault
//  aHG,aLG,bHG,bLG,cHG,cLG out 1 gate drives, 1 = switch on
//  dt_active   out  3  {c,b,a}: phase currently in dead-time
//  flt_latched out  1  fault latch state
// BEHAVIOUR
//  - Reset: all gates 0, dt_active 3'b000, flt_latched 0, every phase FSM in OFF, counters 0.
//  - Per-phase target: xE=0 -> OFF; xE=1,xH1_L0=1 -> HI; xE=1,xH1_L0=0 -> LO.
//  - Per-phase FSM states OFF, DEAD, HI, LO; all outputs registered, 1-cycle latency from inputs.
//    OFF:  target HI/LO -> DEAD (cnt loaded DEAD_CYC-1); target OFF -> stay.
//    DEAD: both gates 0; cnt decrements; target OFF -> OFF immediately; cnt==0 -> current target.
//          Target changing HI<->LO inside DEAD does not restart cnt (both gates already off).
//    HI:   HG=pwm, LG=0. Target LO -> DEAD; target OFF -> OFF (gates 0 next cycle).
//    LO:   LG=1, HG=0 (low side not chopped). Target HI -> DEAD; target OFF -> OFF.
//  - Invariant: xHG & xLG never 1 in the same cycle; after any switch turns off, the other
//    switch of that phase stays off >= DEAD_CYC cycles.
//  - dt_active[x]=1 exactly while phase x is in DEAD (or HI_DT, see CONFIGURATION).
//  - Fault: fault=1 or m3step==4'd7 sets flt_latched next cycle; in that same cycle all six gates
//    forced 0 and every FSM forced to OFF. Held while flt_latched=1, regardless of inputs.
//  - flt_clr=1 with fault=0 and m3step!=7 clears flt_latched; flt_clr ignored while a fault source
//    is active. Set wins over clear in the same cycle. After clear, phases restart from OFF, so
//    first turn-on passes through full DEAD_CYC.
//  - rst mid-operation: next cycle identical to reset state; no gate glitches high.
//  - Phases are independent; simultaneous target changes on all three are handled in parallel.
// CONFIGURATION
//  MOTORO3_SYNC_RECT_EN defined: HI state splits into HI_ON (HG=1), HI_DT (both 0, counting),
//   HI_LS (LG=1, synchronous rectification). pwm rise: HI_LS->HI_DT->HI_ON after DEAD_CYC;
//   pwm fall: HI_ON->HI_DT->HI_LS after DEAD_CYC; pwm reversing during HI_DT reloads the counter
//   and retargets. Entry from DEAD goes to HI_ON if pwm=1 else HI_LS. HI->LO/OFF rules unchanged.
//  Not defined: HI state as above (HG=pwm, LG=0); HI_DT does not exist; dt_active only for DEAD.
// TESTING
//  1 rst=1 2 cycles, pwm toggling, aE=1 -> all gates 0, dt_active=0, flt_latched=0 throughout.
//  2 aE=1,aH1_L0=1,pwm=1 from OFF -> aHG/aLG 0 for 20 cycles, dt_active[0]=1; aHG=1 on cycle 21.
//  3 phase a in HI, aH1_L0 1->0 -> aHG=0 next cycle, both 0 for 20 cycles, then aLG=1; never both 1.
//  4 phase b in LO, fault pulse 1 cycle -> all gates 0 next cycle, flt_latched=1; flt_clr while
//    m3step=7 ignored; flt_clr after m3step=1 clears, bLG returns after 20 dead cycles.
//  5 bE=0 while b in DEAD (cnt=5) -> phase b OFF next cycle, dt_active[1]=0.
//  6 SYNC_RECT_EN, aH1_L0=1, pwm 50% period 200 cycles -> aHG high 80 cycles, aLG high 80 cycles,
//    20-cycle both-off gaps at each pwm edge; random stimulus checker: no aHG&aLG ever.

Source files
------------

// File: rtl/motoro3_gate_deadtime.sv
// Six-switch half-bridge gate driver: per-phase dead-time FSMs plus a latched fault shutdown.
// Optional synchronous rectification of the high-side chop is enabled by MOTORO3_SYNC_RECT_EN.
module motoro3_gate_deadtime #(
    parameter int DEAD_CYC = 20,
    parameter int DW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm,
    input  logic       aE,
    input  logic       bE,
    input  logic       cE,
    input  logic       aH1_L0,
    input  logic       bH1_L0,
    input  logic       cH1_L0,
    input  logic [3:0] m3step,
    input  logic       fault,
    input  logic       flt_clr,
    output logic       aHG,
    output logic       aLG,
    output logic       bHG,
    output logic       bLG,
    output logic       cHG,
    output logic       cLG,
    output logic [2:0] dt_active,
    output logic       flt_latched
);

    // ST_HI is the high-side conducting state; with sync rectification it acts as HI_ON.
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DEAD  = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3
`ifdef MOTORO3_SYNC_RECT_EN
        ,
        ST_HI_DT = 3'd4,
        ST_HI_LS = 3'd5
`endif
    } phase_state_t;

    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);
    localparam logic [DW-1:0] CNT_ONE   = DW'(1);

    logic       r_flt_latched;
    logic       w_fault_src;
    logic       w_force;
    logic [2:0] w_en;
    logic [2:0] w_hi_sel;
    logic [2:0] w_hg;
    logic [2:0] w_lg;
    logic [2:0] w_dt;

    assign w_fault_src = fault || (m3step == 4'd7);
    assign w_force     = w_fault_src || r_flt_latched;
    assign w_en        = {cE, bE, aE};
    assign w_hi_sel    = {cH1_L0, bH1_L0, aH1_L0};

    // Set has priority, so a clear pulse is ignored while any fault source is still active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flt_latched <= 1'b0;
        end else if (w_fault_src) begin
            r_flt_latched <= 1'b1;
        end else if (flt_clr) begin
            r_flt_latched <= 1'b0;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_phase
        phase_state_t  r_state;
        phase_state_t  w_state_nxt;
        logic [DW-1:0] r_cnt;
        logic [DW-1:0] w_cnt_nxt;
        logic          r_hg;
        logic          r_lg;
        logic          r_dt;
        logic          w_hg_nxt;
        logic          w_lg_nxt;
        logic          w_dt_nxt;
        logic          w_tgt_on;
        logic          w_tgt_hi;
        logic          w_tgt_lo;
`ifdef MOTORO3_SYNC_RECT_EN
        logic          r_dir;
        logic          w_dir_nxt;
`endif

        assign w_tgt_on = w_en[g];
        assign w_tgt_hi = w_en[g] && w_hi_sel[g];
        assign w_tgt_lo = w_en[g] && !w_hi_sel[g];

        always_comb begin
            // NOTE: every variable driven here gets a default first, so no path can infer a latch.
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
`ifdef MOTORO3_SYNC_RECT_EN
            w_dir_nxt   = r_dir;
`endif
            case (r_state)
                ST_OFF: begin
                    if (w_tgt_on) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    if (!w_tgt_on) begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else if (w_tgt_lo) begin
                        w_state_nxt = ST_LO;
`ifdef MOTORO3_SYNC_RECT_EN
                    end else begin
                        w_state_nxt = pwm ? ST_HI : ST_HI_LS;
                        w_dir_nxt   = pwm;
                    end
`else
                    end else begin
                        w_state_nxt = ST_HI;
                    end
`endif
                end
                ST_HI: begin
                    if (!w_tgt_on) begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = '0;
                    end else if (w_tgt_lo) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = DEAD_LOAD;
`ifdef MOTORO3_SYNC_RECT_EN
                    end else if (!pwm) begin
                        w_state_nxt = ST_HI_DT;
                        w_cnt_nxt   = DEAD_LOAD;
                        w_dir_nxt   = 1'b0;
`endif
                    end
                end
                ST_LO: begin
                    if (!w_tgt_on) begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = '0;
                    end else if (w_tgt_hi) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = DEAD_LOAD;
                    end
                end
`ifdef MOTORO3_SYNC_RECT_EN
                ST_HI_DT: begin
                    // r_dir holds the side the gap is heading to; a pwm reversal retargets and restarts it.
                    if (!w_tgt_on) begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = '0;
                    end else if (w_tgt_lo) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = DEAD_LOAD;
                    end else if (pwm != r_dir) begin
                        w_cnt_nxt = DEAD_LOAD;
                        w_dir_nxt = pwm;
                    end else if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        w_state_nxt = r_dir ? ST_HI : ST_HI_LS;
                    end
                end
                ST_HI_LS: begin
                    if (!w_tgt_on) begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = '0;
                    end else if (w_tgt_lo) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = DEAD_LOAD;
                    end else if (pwm) begin
                        w_state_nxt = ST_HI_DT;
                        w_cnt_nxt   = DEAD_LOAD;
                        w_dir_nxt   = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase

            if (w_force) begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = '0;
            end

`ifdef MOTORO3_SYNC_RECT_EN
            w_hg_nxt = (w_state_nxt == ST_HI);
            w_lg_nxt = (w_state_nxt == ST_LO) || (w_state_nxt == ST_HI_LS);
            w_dt_nxt = (w_state_nxt == ST_DEAD) || (w_state_nxt == ST_HI_DT);
`else
            w_hg_nxt = (w_state_nxt == ST_HI) && pwm;
            w_lg_nxt = (w_state_nxt == ST_LO);
            w_dt_nxt = (w_state_nxt == ST_DEAD);
`endif
        end

        always_ff @(posedge clk) begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            if (rst) begin
                r_state <= ST_OFF;
                r_cnt   <= '0;
                r_hg    <= 1'b0;
                r_lg    <= 1'b0;
                r_dt    <= 1'b0;
`ifdef MOTORO3_SYNC_RECT_EN
                r_dir   <= 1'b0;
`endif
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_hg    <= w_hg_nxt;
                r_lg    <= w_lg_nxt;
                r_dt    <= w_dt_nxt;
`ifdef MOTORO3_SYNC_RECT_EN
                r_dir   <= w_dir_nxt;
`endif
            end
        end

        assign w_hg[g] = r_hg;
        assign w_lg[g] = r_lg;
        assign w_dt[g] = r_dt;
    end

    assign aHG         = w_hg[0];
    assign aLG         = w_lg[0];
    assign bHG         = w_hg[1];
    assign bLG         = w_lg[1];
    assign cHG         = w_hg[2];
    assign cLG         = w_lg[2];
    assign dt_active   = w_dt;
    assign flt_latched = r_flt_latched;

endmodule

// File: tb/tb_motoro3_gate_deadtime.sv
// Directed bench for motoro3_gate_deadtime with shoot-through and dead-gap monitors.
// Gate vectors are packed {aHG,aLG,bHG,bLG,cHG,cLG}; dt_active is {c,b,a}.
module tb_motoro3_gate_deadtime;

    localparam int DEAD = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm;
    logic       aE, bE, cE;
    logic       aH1_L0, bH1_L0, cH1_L0;
    logic [3:0] m3step;
    logic       fault;
    logic       flt_clr;
    logic       aHG, aLG, bHG, bLG, cHG, cLG;
    logic [2:0] dt_active;
    logic       flt_latched;

    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic [5:0] w_gates;
    logic [2:0] w_hg;
    logic [2:0] w_lg;
`ifdef MOTORO3_SYNC_RECT_EN
    int         hg_n, lg_n, off_n;
`endif

    assign w_gates = {aHG, aLG, bHG, bLG, cHG, cLG};
    assign w_hg    = {cHG, bHG, aHG};
    assign w_lg    = {cLG, bLG, aLG};

    always #50 clk = ~clk;

    motoro3_gate_deadtime #(.DEAD_CYC(DEAD), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm        (pwm),
        .aE         (aE),
        .bE         (bE),
        .cE         (cE),
        .aH1_L0     (aH1_L0),
        .bH1_L0     (bH1_L0),
        .cH1_L0     (cH1_L0),
        .m3step     (m3step),
        .fault      (fault),
        .flt_clr    (flt_clr),
        .aHG        (aHG),
        .aLG        (aLG),
        .bHG        (bHG),
        .bLG        (bLG),
        .cHG        (cHG),
        .cLG        (cLG),
        .dt_active  (dt_active),
        .flt_latched(flt_latched)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [5:0] g, input logic [2:0] dt,
                                input logic fl);
        check({tag, "_gates"}, 32'(w_gates), 32'(g));
        check({tag, "_dt"}, 32'(dt_active), 32'(dt));
        check({tag, "_flt"}, 32'(flt_latched), 32'(fl));
    endtask

    // First tick enters the gap; DEAD cycles with g_dead, then the on-state on the next cycle.
    task automatic run_dead(input string tag, input logic [5:0] g_dead, input logic [2:0] dt_dead,
                            input logic [5:0] g_on, input logic [2:0] dt_on);
        for (int i = 0; i < DEAD; i++) begin
            tick();
            expect_state({tag, "_dead"}, g_dead, dt_dead, 1'b0);
        end
        tick();
        expect_state({tag, "_on"}, g_on, dt_on, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) check("no_shoot_through", 32'(w_hg & w_lg), 32'd0);
    end

    // A switch may turn on only after the opposite switch of its phase has been off >= DEAD cycles.
    for (genvar p = 0; p < 3; p++) begin : g_mon
        int off_cnt = 0;
        int last_on = 0;
        always @(negedge clk) begin
            if (mon_en) begin
                if (w_hg[p]) begin
                    if (last_on == 2) check("deadgap_lo_to_hi", 32'(off_cnt >= DEAD), 32'd1);
                    last_on <= 1;
                    off_cnt <= 0;
                end else if (w_lg[p]) begin
                    if (last_on == 1) check("deadgap_hi_to_lo", 32'(off_cnt >= DEAD), 32'd1);
                    last_on <= 2;
                    off_cnt <= 0;
                end else begin
                    off_cnt <= off_cnt + 1;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pwm = 1'b0; m3step = 4'd1; fault = 1'b0; flt_clr = 1'b0;
        aE = 1'b1; bE = 1'b0; cE = 1'b0;
        aH1_L0 = 1'b1; bH1_L0 = 1'b0; cH1_L0 = 1'b0;

        tick();
        expect_state("reset_1", 6'b00_00_00, 3'b000, 1'b0);
        pwm = 1'b1;
        tick();
        expect_state("reset_2", 6'b00_00_00, 3'b000, 1'b0);
        mon_en = 1'b1;

        rst = 1'b0;
        run_dead("a_off_to_hi", 6'b00_00_00, 3'b001, 6'b10_00_00, 3'b000);

        aH1_L0 = 1'b0;
        run_dead("a_hi_to_lo", 6'b00_00_00, 3'b001, 6'b01_00_00, 3'b000);

        bE = 1'b1;
        run_dead("b_off_to_lo", 6'b01_00_00, 3'b010, 6'b01_01_00, 3'b000);

        fault = 1'b1;
        tick();
        expect_state("fault_set", 6'b00_00_00, 3'b000, 1'b1);
        fault = 1'b0;
        tick();
        expect_state("fault_hold", 6'b00_00_00, 3'b000, 1'b1);
        m3step = 4'd7; flt_clr = 1'b1;
        tick();
        expect_state("clr_during_stop", 6'b00_00_00, 3'b000, 1'b1);
        flt_clr = 1'b0;
        tick();
        expect_state("stop_hold", 6'b00_00_00, 3'b000, 1'b1);
        m3step = 4'd1;
        tick();
        expect_state("latched_no_clr", 6'b00_00_00, 3'b000, 1'b1);
        flt_clr = 1'b1;
        tick();
        expect_state("fault_cleared", 6'b00_00_00, 3'b000, 1'b0);
        flt_clr = 1'b0;
        run_dead("restart_after_clr", 6'b00_00_00, 3'b011, 6'b01_01_00, 3'b000);

        bH1_L0 = 1'b1;
        repeat (15) tick();
        expect_state("b_dead_cnt5", 6'b01_00_00, 3'b010, 1'b0);
        bE = 1'b0;
        tick();
        expect_state("b_off_from_dead", 6'b01_00_00, 3'b000, 1'b0);
        tick();
        expect_state("b_stays_off", 6'b01_00_00, 3'b000, 1'b0);
        bE = 1'b1;
        run_dead("b_off_to_hi", 6'b01_00_00, 3'b010, 6'b01_10_00, 3'b000);

        fault = 1'b1;
        tick();
        expect_state("fault_again", 6'b00_00_00, 3'b000, 1'b1);
        fault = 1'b0; rst = 1'b1;
        tick();
        expect_state("reset_mid", 6'b00_00_00, 3'b000, 1'b0);
        rst = 1'b0;
        run_dead("after_reset", 6'b00_00_00, 3'b011, 6'b01_10_00, 3'b000);

        fault = 1'b1; flt_clr = 1'b1;
        tick();
        expect_state("set_over_clr", 6'b00_00_00, 3'b000, 1'b1);
        fault = 1'b0;
        tick();
        expect_state("clr_after_set", 6'b00_00_00, 3'b000, 1'b0);
        flt_clr = 1'b0;

        cE = 1'b1; cH1_L0 = 1'b0; aH1_L0 = 1'b1; bH1_L0 = 1'b0;
        run_dead("all_three_on", 6'b00_00_00, 3'b111, 6'b10_01_01, 3'b000);
        aH1_L0 = 1'b0; bH1_L0 = 1'b1; cH1_L0 = 1'b1;
        run_dead("all_three_swap", 6'b00_00_00, 3'b111, 6'b01_10_10, 3'b000);

        aH1_L0 = 1'b1;
        repeat (10) tick();
        expect_state("a_dead_half", 6'b00_10_10, 3'b001, 1'b0);
        aH1_L0 = 1'b0;
        repeat (10) tick();
        expect_state("a_flip_no_restart", 6'b00_10_10, 3'b001, 1'b0);
        tick();
        expect_state("a_flip_lo_on", 6'b01_10_10, 3'b000, 1'b0);

        aH1_L0 = 1'b1;
        run_dead("a_lo_to_hi", 6'b00_10_10, 3'b001, 6'b10_10_10, 3'b000);

`ifdef MOTORO3_SYNC_RECT_EN
        pwm = 1'b0;
        run_dead("pwm_fall", 6'b00_00_00, 3'b111, 6'b01_01_01, 3'b000);
        hg_n = 0; lg_n = 0; off_n = 0;
        pwm = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) pwm = 1'b0;
            tick();
            if (aHG) hg_n++;
            if (aLG) lg_n++;
            if (!aHG && !aLG) off_n++;
        end
        check("period_hg_cycles", 32'(hg_n), 32'd80);
        check("period_lg_cycles", 32'(lg_n), 32'd80);
        check("period_off_cycles", 32'(off_n), 32'd40);
        pwm = 1'b1;
        repeat (5) tick();
        pwm = 1'b0;
        run_dead("pwm_reverse", 6'b00_00_00, 3'b111, 6'b01_01_01, 3'b000);
`else
        pwm = 1'b0;
        tick();
        expect_state("chop_low", 6'b00_00_00, 3'b000, 1'b0);
        pwm = 1'b1;
        tick();
        expect_state("chop_high", 6'b10_10_10, 3'b000, 1'b0);
`endif

        aE = 1'b0;
        tick();
        expect_state("a_hi_to_off", {2'b00, w_gates[3:0]}, 3'b000, 1'b0);
        check("a_off_gates", 32'({aHG, aLG}), 32'd0);
        aE = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) pwm = ~pwm;
            if ($urandom_range(0, 39) == 0) aE = ~aE;
            if ($urandom_range(0, 39) == 0) bE = ~bE;
            if ($urandom_range(0, 39) == 0) cE = ~cE;
            if ($urandom_range(0, 29) == 0) aH1_L0 = ~aH1_L0;
            if ($urandom_range(0, 29) == 0) bH1_L0 = ~bH1_L0;
            if ($urandom_range(0, 29) == 0) cH1_L0 = ~cH1_L0;
            fault   = ($urandom_range(0, 499) == 0);
            flt_clr = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
